// File: rtl/shift_codec_pkg.sv
// shift_codec_pkg
// Definitions shared by the left-shift encoder and the shift decoder:
//   SHIFT_DEFAULT  default encoder shift amount
//   WIDTH_DEFAULT  default encoded/decoded word width
//   state_t        lock state machine encoding {HUNT, LOCKED}
//   word_t         decoded word as it travels downstream {err, data}
package shift_codec_pkg;

    localparam int SHIFT_DEFAULT = 2;
    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    typedef struct packed {
        logic                     err;
        logic [WIDTH_DEFAULT-1:0] data;
    } word_t;

endpackage

// File: rtl/shift_decoder_if.sv
// shift_decoder_if
// Handshake bundle around the shift decoder.
//   in_valid / in_data / in_ready        encoded word stream into the decoder
//   out_valid / out_data / out_err / out_ready  decoded word stream out of it
// Modports:
//   master  the surrounding logic (producer of encoded words, consumer of decoded words)
//   slave   the decoder itself
interface shift_decoder_if #(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    logic             out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/shift_fifo.sv
// shift_fifo
// Synchronous FIFO, DEPTH entries of W bits, with full/empty flags.
//   clk, rst_n  clock and asynchronous active-low reset (flushes the FIFO)
//   push/wdata  write request; ignored while full
//   pop         read request; ignored while empty
//   rdata       head entry, zero while empty
//   full/empty  occupancy flags, derived from the registered count only
module shift_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is refused, so a full FIFO cannot pass a word
    // straight through even if the head is popped in the same cycle.
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty gates rdata until an entry is written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/shift_decoder.sv
// shift_decoder
// Receive side of the left-shift codec. Encoded words carry the payload
// shifted left by SHIFT with the low SHIFT guard bits zero. The decoder
// shifts them back, flags non-zero guard bits, qualifies the stream with a
// HUNT/LOCKED state machine and buffers decoded words in a FIFO.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         shift_decoder_if slave: in_valid/in_data/in_ready,
//               out_valid/out_data/out_err/out_ready
//   locked      state machine is in LOCKED
//   err_count   accepted words with bad guard bits, saturating
module shift_decoder
    import shift_codec_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int SHIFT  = SHIFT_DEFAULT,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 2,
    parameter int LOSS_N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_decoder_if.slave   bus,
    output logic             locked,
    output logic [CNT_W-1:0] err_count
);

    localparam int CLEAN_W = $clog2(LOCK_N + 1);
    localparam int ERR_W   = $clog2(LOSS_N + 1);

    state_t             state;
    logic [CLEAN_W-1:0] clean_run;
    logic [ERR_W-1:0]   err_run;

    logic               accept;
    logic               gerr;
    logic               push;
    logic               full;
    logic               empty;
    logic [WIDTH-1:0]   payload;
    logic [WIDTH:0]     fifo_rdata;

    assign accept  = bus.in_valid & bus.in_ready;
    assign gerr    = |bus.in_data[SHIFT-1:0];
    assign payload = bus.in_data >> SHIFT;

    // While hunting, errored words are dropped; once locked everything is
    // forwarded with its error flag so the consumer sees the damage.
    assign push = accept & ((state == LOCKED) | !gerr);

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_data  = fifo_rdata[WIDTH-1:0];
    assign bus.out_err   = fifo_rdata[WIDTH];

    shift_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (bus.out_ready),
        .wdata ({gerr, payload}),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty)
    );

    // Lock qualification and error statistics. Only accepted words advance
    // anything. The run counters transition on the word that would make them
    // reach their threshold, so they never exceed LOCK_N / LOSS_N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            locked    <= 1'b0;
            clean_run <= '0;
            err_run   <= '0;
            err_count <= '0;
        end else if (accept) begin
            if (gerr && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + CNT_W'(1);
            end
            case (state)
                HUNT: begin
                    if (gerr) begin
                        clean_run <= '0;
                    end else if (clean_run == CLEAN_W'(LOCK_N - 1)) begin
                        state     <= LOCKED;
                        locked    <= 1'b1;
                        clean_run <= '0;
                    end else begin
                        clean_run <= clean_run + CLEAN_W'(1);
                    end
                end
                LOCKED: begin
                    if (!gerr) begin
                        err_run <= '0;
                    end else if (err_run == ERR_W'(LOSS_N - 1)) begin
                        state   <= HUNT;
                        locked  <= 1'b0;
                        err_run <= '0;
                    end else begin
                        err_run <= err_run + ERR_W'(1);
                    end
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_decoder.sv
// tb_shift_decoder
// Directed bench for shift_decoder (WIDTH=8, SHIFT=2, DEPTH=4, CNT_W=4).
// Stimulus pushes hand-computed expected words into a queue; a monitor pops
// and compares whenever the decoder hands a word to the consumer.
module tb_shift_decoder;
    import shift_codec_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       locked;
    logic [3:0] err_count;

    int checks = 0;
    int passes = 0;

    word_t expq[$];
    word_t mon_exp;

    shift_decoder_if #(.WIDTH(8)) bus ();

    shift_decoder #(
        .WIDTH  (8),
        .SHIFT  (2),
        .DEPTH  (4),
        .CNT_W  (4),
        .LOCK_N (2),
        .LOSS_N (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .locked    (locked),
        .err_count (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Send one encoded word; if enq, the decoder must deliver {exp_err, exp_data}.
    task automatic applyStimulus(input logic [7:0] data, input bit enq,
                                 input bit exp_err, input logic [7:0] exp_data);
        int    waited = 0;
        word_t w;
        while (!bus.in_ready && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("in_ready_timeout", 0, 1);
            return;
        end
        if (enq) begin
            w.err  = exp_err;
            w.data = exp_data;
            expq.push_back(w);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expq.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        checkOutput({name, "_drained"}, expq.size(), 0);
        @(posedge clk);
        #1;
        checkOutput({name, "_empty_after"}, int'(bus.out_valid), 0);
    endtask

    // Scoreboard monitor: a word leaves the decoder whenever out_valid & out_ready.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_output", int'(bus.out_data), 256);
            end else begin
                mon_exp = expq.pop_front();
                checkOutput("out_data", int'(bus.out_data), int'(mon_exp.data));
                checkOutput("out_err", int'(bus.out_err), int'(mon_exp.err));
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_out_data", int'(bus.out_data), 0);
        checkOutput("rst_out_err", int'(bus.out_err), 0);
        checkOutput("rst_locked", int'(locked), 0);
        checkOutput("rst_err_count", int'(err_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lock acquisition from HUNT
        bus.out_ready = 1'b1;
        applyStimulus(8'h05, 1'b0, 1'b0, 8'h00);
        checkOutput("hunt_drop_err_count", int'(err_count), 1);
        checkOutput("hunt_drop_out_valid", int'(bus.out_valid), 0);
        applyStimulus(8'h04, 1'b1, 1'b0, 8'h01);
        checkOutput("hunt_one_clean_locked", int'(locked), 0);
        applyStimulus(8'h08, 1'b1, 1'b0, 8'h02);
        checkOutput("lock_acquired", int'(locked), 1);
        waitDrain("lock");

        // Errored words while locked are delivered, third one loses lock
        applyStimulus(8'h07, 1'b1, 1'b1, 8'h01);
        checkOutput("lerr1_err_count", int'(err_count), 2);
        checkOutput("lerr1_locked", int'(locked), 1);
        applyStimulus(8'h03, 1'b1, 1'b1, 8'h00);
        checkOutput("lerr2_err_count", int'(err_count), 3);
        checkOutput("lerr2_locked", int'(locked), 1);
        applyStimulus(8'h03, 1'b1, 1'b1, 8'h00);
        checkOutput("lerr3_err_count", int'(err_count), 4);
        checkOutput("lock_lost", int'(locked), 0);
        waitDrain("lerr");

        // Backpressure: fill the FIFO, head must hold until popped
        bus.out_ready = 1'b0;
        applyStimulus(8'h10, 1'b1, 1'b0, 8'h04);
        applyStimulus(8'h20, 1'b1, 1'b0, 8'h08);
        applyStimulus(8'h30, 1'b1, 1'b0, 8'h0C);
        applyStimulus(8'h40, 1'b1, 1'b0, 8'h10);
        checkOutput("full_in_ready", int'(bus.in_ready), 0);
        checkOutput("full_out_valid", int'(bus.out_valid), 1);
        checkOutput("full_head", int'(bus.out_data), 8'h04);
        checkOutput("relock_locked", int'(locked), 1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("held_head", int'(bus.out_data), 8'h04);
        checkOutput("held_head_err", int'(bus.out_err), 0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_pop", int'(bus.in_ready), 1);
        waitDrain("backpressure");

        // Simultaneous push and pop at occupancy 2
        bus.out_ready = 1'b0;
        applyStimulus(8'h44, 1'b1, 1'b0, 8'h11);
        applyStimulus(8'h48, 1'b1, 1'b0, 8'h12);
        checkOutput("occ_prefill", int'(dut.u_fifo.count), 2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            word_t w;
            logic [7:0] pl;
            pl           = 8'h20 + 8'(i);
            w.err        = 1'b0;
            w.data       = pl;
            expq.push_back(w);
            bus.in_valid = 1'b1;
            bus.in_data  = {pl[5:0], 2'b00};
            @(posedge clk);
            #1;
            checkOutput("occ_steady", int'(dut.u_fifo.count), 2);
        end
        bus.in_valid = 1'b0;
        waitDrain("pushpop");

        // err_count saturation: first three errored words forwarded, rest dropped
        for (int i = 0; i < 20; i++) begin
            applyStimulus(8'h01, (i < 3), 1'b1, 8'h00);
            if (i == 2) begin
                checkOutput("sat_lock_lost", int'(locked), 0);
            end
            if (i == 10) begin
                checkOutput("sat_reached", int'(err_count), 15);
            end
        end
        checkOutput("sat_held", int'(err_count), 15);
        waitDrain("saturation");

        // Reset in the middle of the stream with three words buffered
        bus.out_ready = 1'b0;
        applyStimulus(8'h04, 1'b1, 1'b0, 8'h01);
        applyStimulus(8'h08, 1'b1, 1'b0, 8'h02);
        applyStimulus(8'h0C, 1'b1, 1'b0, 8'h03);
        checkOutput("pre_rst_out_valid", int'(bus.out_valid), 1);
        checkOutput("pre_rst_locked", int'(locked), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("mid_rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("mid_rst_locked", int'(locked), 0);
        checkOutput("mid_rst_err_count", int'(err_count), 0);
        checkOutput("mid_rst_out_data", int'(bus.out_data), 0);
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        applyStimulus(8'h14, 1'b1, 1'b0, 8'h05);
        checkOutput("post_rst_locked", int'(locked), 0);
        waitDrain("post_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
